// File: rtl/riscv64g_iss_csr_exec.sv
// riscv64g_iss_csr_exec: Zicsr/ECALL/MRET sequencer for the machine CSR file; define ISS_CSR_ILLEGAL_EN to trap writes to read-only CSRs
module riscv64g_iss_csr_exec #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [4:0]      req_rs1_idx,
  input  logic [4:0]      req_rd_idx,
  input  logic [XLEN-1:0] req_pc,
  output logic            rsp_valid,
  output logic            rsp_rd_we,
  output logic [XLEN-1:0] rsp_rd_val,
  output logic            rsp_redirect,
  output logic [XLEN-1:0] rsp_pc,
  output logic            csr_we,
  output logic [11:0]     csr_a,
  input  logic [XLEN-1:0] csr_rd,
  output logic [XLEN-1:0] csr_wd
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, T_EPC, T_CAUSE, T_VEC, M_RD, RSP} state_t;
  state_t state, state_n;
  logic [1:0] kind;
  logic [11:0] csr;
  logic [4:0] rd_idx;
  logic [3:0] cause;
  logic [XLEN-1:0] pc, src, old, target, new_val;
  logic wr_need, redir, illegal, imm_form;
`ifdef ISS_CSR_ILLEGAL_EN
  assign illegal = wr_need && csr[11:10] == 2'b11;
`else
  assign illegal = 1'b0;
`endif
  assign imm_form = req_op[2] && req_op[1:0] != 2'b00;
  // next-state selection
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = req_op == 3'd0 ? T_EPC : req_op == 3'd4 ? M_RD : READ;
      READ:    state_n = illegal ? T_EPC : wr_need ? WRITE : RSP;
      T_EPC:   state_n = T_CAUSE;
      T_CAUSE: state_n = T_VEC;
      RSP:     state_n = IDLE;
      default: state_n = RSP;
    endcase
  end
  // register-file port and response drive, all zero outside active states
  always_comb begin
    new_val = kind == 2'b01 ? src : kind == 2'b10 ? (old | src) : (old & ~src);
    req_ready = state == IDLE;
    csr_we = state == WRITE || state == T_EPC || state == T_CAUSE;
    csr_a = (state == READ || state == WRITE) ? csr :
            (state == T_EPC || state == M_RD) ? 12'h341 :
            state == T_CAUSE ? 12'h342 :
            state == T_VEC ? 12'h305 : 12'h000;
    csr_wd = state == WRITE ? new_val :
             state == T_EPC ? pc :
             state == T_CAUSE ? {{(XLEN-4){1'b0}}, cause} : '0;
    rsp_valid = state == RSP;
    rsp_rd_we = rsp_valid && !redir && rd_idx != 5'd0;
    rsp_rd_val = rsp_valid ? old : '0;
    rsp_redirect = rsp_valid && redir;
    rsp_pc = (rsp_valid && redir) ? target : '0;
  end
  // state register plus command, old-value and trap-target latches
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state <= IDLE;
      kind <= '0;
      csr <= '0;
      rd_idx <= '0;
      cause <= '0;
      pc <= '0;
      src <= '0;
      old <= '0;
      target <= '0;
      wr_need <= 1'b0;
      redir <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        kind <= req_op[1:0];
        csr <= req_csr;
        rd_idx <= req_rd_idx;
        pc <= req_pc;
        src <= imm_form ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1;
        wr_need <= req_op[1:0] == 2'b01 || req_rs1_idx != 5'd0;
        redir <= req_op == 3'd0 || req_op == 3'd4;
        cause <= 4'd11;
      end
      if (state == READ) begin
        old <= csr_rd;
        if (illegal) begin
          redir <= 1'b1;
          cause <= 4'd2;
        end
      end
      if (state == T_VEC) target <= {csr_rd[XLEN-1:2], 2'b00};
      if (state == M_RD) target <= csr_rd;
    end
endmodule

// File: tb/tb_riscv64g_iss_csr_exec.sv
// tb_riscv64g_iss_csr_exec: directed vectors, reset abort and random commands against a CSR-file model
module tb_riscv64g_iss_csr_exec;
  logic CLK = 1'b0, RSTn = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_op = '0;
  logic [11:0] req_csr = '0;
  logic [63:0] req_rs1 = '0, req_pc = '0;
  logic [4:0] req_rs1_idx = '0, req_rd_idx = '0;
  logic rsp_valid, rsp_rd_we, rsp_redirect, csr_we;
  logic [63:0] rsp_rd_val, rsp_pc, csr_rd, csr_wd;
  logic [11:0] csr_a;
  always #5 CLK = ~CLK;
  riscv64g_iss_csr_exec dut (
    .CLK(CLK), .RSTn(RSTn), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr(req_csr), .req_rs1(req_rs1), .req_rs1_idx(req_rs1_idx), .req_rd_idx(req_rd_idx),
    .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_rd_we(rsp_rd_we), .rsp_rd_val(rsp_rd_val),
    .rsp_redirect(rsp_redirect), .rsp_pc(rsp_pc), .csr_we(csr_we), .csr_a(csr_a),
    .csr_rd(csr_rd), .csr_wd(csr_wd)
  );
  // CSR register file model: combinational read (mhartid reads zero), write at clock edge
  logic [63:0] rf [0:4095] = '{default: 64'd0};
  logic pre_we = 1'b0;
  logic [11:0] pre_a = '0;
  logic [63:0] pre_d = '0;
  assign csr_rd = csr_a == 12'hF14 ? 64'd0 : rf[csr_a];
  always @(posedge CLK) if (csr_we) rf[csr_a] <= csr_wd; else if (pre_we) rf[pre_a] <= pre_d;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  typedef struct { logic [11:0] a; logic [63:0] d; int c; } wr_t;
  wr_t wlog[$], ew[$];
  always @(negedge CLK) if (csr_we) wlog.push_back('{csr_a, csr_wd, cyc});
  typedef struct { logic [2:0] op; logic [11:0] csr; logic [63:0] rs1; logic [4:0] idx, rd; logic [63:0] pc; } cmd_t;
  typedef struct {
    bit pre; logic [11:0] pa; logic [63:0] pv;
    logic [2:0] op; logic [11:0] csr; logic [63:0] rs1; logic [4:0] idx, rd; logic [63:0] pc;
    int lat; logic we; logic [63:0] val; logic rdr; logic [63:0] tgt;
    int nw; logic [11:0] a0; logic [63:0] d0; int c0; logic [11:0] a1; logic [63:0] d1; int c1;
  } vec_t;
  vec_t tv [9];
  int checks = 0, errors = 0;
  int d_lat;
  logic d_we, d_rdr;
  logic [63:0] d_val, d_tgt;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic preset(input logic [11:0] a, input logic [63:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask
  function automatic logic [63:0] rdv(input logic [11:0] a);
    return a == 12'hF14 ? 64'd0 : rf[a];
  endfunction
  task automatic model(input cmd_t c, output int lat, output logic we, output logic [63:0] val,
                       output logic rdr, output logic [63:0] tgt);
    logic [63:0] o, s, nv;
    logic need, ill;
    ew.delete();
    o = rdv(c.csr); we = 1'b0; val = o; rdr = 1'b0; tgt = 64'd0; lat = 2;
    s = c.op >= 3'd5 ? {59'd0, c.idx} : c.rs1;
    if (c.op == 3'd0) begin
      ew.push_back('{12'h341, c.pc, 1}); ew.push_back('{12'h342, 64'd11, 2});
      lat = 4; rdr = 1'b1; tgt = rdv(12'h305) & ~64'd3;
    end else if (c.op == 3'd4) begin
      rdr = 1'b1; tgt = rdv(12'h341);
    end else begin
      need = c.op == 3'd1 || c.op == 3'd5 || c.idx != 5'd0;
      nv = (c.op == 3'd1 || c.op == 3'd5) ? s : (c.op == 3'd2 || c.op == 3'd6) ? (o | s) : (o & ~s);
      ill = 1'b0;
`ifdef ISS_CSR_ILLEGAL_EN
      ill = need && c.csr >= 12'hC00;
`endif
      if (ill) begin
        ew.push_back('{12'h341, c.pc, 2}); ew.push_back('{12'h342, 64'd2, 3});
        lat = 5; rdr = 1'b1; tgt = rdv(12'h305) & ~64'd3;
      end else begin
        we = c.rd != 5'd0;
        if (need) begin
          ew.push_back('{c.csr, nv, 2});
          lat = 3;
        end
      end
    end
  endtask
  task automatic run(input cmd_t c);
    int acc;
    wlog.delete();
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = c.op; req_csr = c.csr; req_rs1 = c.rs1;
    req_rs1_idx = c.idx; req_rd_idx = c.rd; req_pc = c.pc;
    @(negedge CLK);
    req_valid = 1'b0; acc = cyc; d_lat = 0; d_we = 1'b0; d_val = '0; d_rdr = 1'b0; d_tgt = '0;
    for (int k = 1; k <= 8; k++) begin
      if (rsp_valid) begin
        d_lat = k; d_we = rsp_rd_we; d_val = rsp_rd_val; d_rdr = rsp_redirect; d_tgt = rsp_pc;
        break;
      end
      @(negedge CLK);
    end
    for (int i = 0; i < wlog.size(); i++) wlog[i].c = wlog[i].c - acc + 1;
    @(negedge CLK);
  endtask
  task automatic cmp(input string n, input int lat, input logic we, input logic [63:0] val,
                     input logic rdr, input logic [63:0] tgt);
    chk({n, ".latency"}, 64'(d_lat), 64'(lat));
    chk({n, ".rd_we"}, {63'd0, d_we}, {63'd0, we});
    chk({n, ".redirect"}, {63'd0, d_rdr}, {63'd0, rdr});
    if (rdr) chk({n, ".rsp_pc"}, d_tgt, tgt);
    else chk({n, ".rd_val"}, d_val, val);
    chk({n, ".nwrites"}, 64'(wlog.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < wlog.size(); i++) begin
      chk({n, ".wr_addr"}, {52'd0, wlog[i].a}, {52'd0, ew[i].a});
      chk({n, ".wr_data"}, wlog[i].d, ew[i].d);
      chk({n, ".wr_cycle"}, 64'(wlog[i].c), 64'(ew[i].c));
    end
  endtask
  initial begin
    cmd_t c;
    int lat;
    logic we, rdr;
    logic [63:0] val, tgt;
    logic [11:0] cl [7];
    int seen;
    cl = '{12'h340, 12'h305, 12'h341, 12'h342, 12'hF14, 12'h300, 12'hC00};
    tv[0] = '{1'b1, 12'h305, 64'h0, 3'd1, 12'h305, 64'h8000_0100, 5'd1, 5'd5, 64'h0,
              3, 1'b1, 64'h0, 1'b0, 64'h0, 1, 12'h305, 64'h8000_0100, 2, 12'h0, 64'h0, 0};
    tv[1] = '{1'b1, 12'h340, 64'h1234, 3'd2, 12'h340, 64'hFFFF, 5'd0, 5'd3, 64'h0,
              2, 1'b1, 64'h1234, 1'b0, 64'h0, 0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 0};
    tv[2] = '{1'b1, 12'h340, 64'hF, 3'd7, 12'h340, 64'hFFFF_FFFF, 5'd5, 5'd4, 64'h0,
              3, 1'b1, 64'hF, 1'b0, 64'h0, 1, 12'h340, 64'hA, 2, 12'h0, 64'h0, 0};
    tv[3] = '{1'b0, 12'h0, 64'h0, 3'd2, 12'h340, 64'h0, 5'd0, 5'd6, 64'h0,
              2, 1'b1, 64'hA, 1'b0, 64'h0, 0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 0};
    tv[4] = '{1'b1, 12'h305, 64'h8000_0103, 3'd0, 12'h0, 64'h0, 5'd0, 5'd0, 64'h1000,
              4, 1'b0, 64'h0, 1'b1, 64'h8000_0100, 2, 12'h341, 64'h1000, 1, 12'h342, 64'hB, 2};
    tv[5] = '{1'b1, 12'h341, 64'h1004, 3'd4, 12'h0, 64'h0, 5'd0, 5'd0, 64'h0,
              2, 1'b0, 64'h0, 1'b1, 64'h1004, 0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 0};
`ifdef ISS_CSR_ILLEGAL_EN
    tv[6] = '{1'b0, 12'h0, 64'h0, 3'd1, 12'hF14, 64'h55, 5'd2, 5'd7, 64'h2000,
              5, 1'b0, 64'h0, 1'b1, 64'h8000_0100, 2, 12'h341, 64'h2000, 2, 12'h342, 64'h2, 3};
`else
    tv[6] = '{1'b0, 12'h0, 64'h0, 3'd1, 12'hF14, 64'h55, 5'd2, 5'd7, 64'h2000,
              3, 1'b1, 64'h0, 1'b0, 64'h0, 1, 12'hF14, 64'h55, 2, 12'h0, 64'h0, 0};
`endif
    tv[7] = '{1'b1, 12'h300, 64'h88, 3'd6, 12'h300, 64'hFFFF, 5'd0, 5'd0, 64'h0,
              2, 1'b0, 64'h88, 1'b0, 64'h0, 0, 12'h0, 64'h0, 0, 12'h0, 64'h0, 0};
    tv[8] = '{1'b1, 12'h340, 64'h99, 3'd5, 12'h340, 64'hFFFF, 5'd0, 5'd1, 64'h0,
              3, 1'b1, 64'h99, 1'b0, 64'h0, 1, 12'h340, 64'h0, 2, 12'h0, 64'h0, 0};
    repeat (2) @(negedge CLK);
    chk("reset.req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset.rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset.csr_we", {63'd0, csr_we}, 64'd0);
    chk("reset.csr_a", {52'd0, csr_a}, 64'd0);
    chk("reset.csr_wd", csr_wd, 64'd0);
    chk("reset.rsp_pc", rsp_pc, 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 9; i++) begin
      if (tv[i].pre) preset(tv[i].pa, tv[i].pv);
      c = '{tv[i].op, tv[i].csr, tv[i].rs1, tv[i].idx, tv[i].rd, tv[i].pc};
      ew.delete();
      if (tv[i].nw > 0) ew.push_back('{tv[i].a0, tv[i].d0, tv[i].c0});
      if (tv[i].nw > 1) ew.push_back('{tv[i].a1, tv[i].d1, tv[i].c1});
      run(c);
      cmp($sformatf("vec%0d", i), tv[i].lat, tv[i].we, tv[i].val, tv[i].rdr, tv[i].tgt);
    end
    preset(12'h340, 64'h77);
    req_valid = 1'b1; req_op = 3'd1; req_csr = 12'h340; req_rs1 = 64'h3; req_rs1_idx = 5'd1; req_rd_idx = 5'd1;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    chk("abort.we_in_write", {63'd0, csr_we}, 64'd1);
    #1 RSTn = 1'b0;
    #1;
    chk("abort.we_async", {63'd0, csr_we}, 64'd0);
    chk("abort.csr_a", {52'd0, csr_a}, 64'd0);
    chk("abort.ready", {63'd0, req_ready}, 64'd1);
    @(negedge CLK);
    RSTn = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      seen += int'(rsp_valid);
    end
    chk("abort.no_rsp", 64'(seen), 64'd0);
    chk("abort.not_written", rf[12'h340], 64'h77);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) preset(12'h305, {$urandom, $urandom});
      c.op = 3'($urandom_range(0, 7));
      c.csr = cl[$urandom_range(0, 6)];
      c.rs1 = {$urandom, $urandom};
      c.idx = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
      c.rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
      c.pc = {$urandom, $urandom};
      model(c, lat, we, val, rdr, tgt);
      run(c);
      cmp($sformatf("rnd%0d", n), lat, we, val, rdr, tgt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
